// File: rtl/mips_sort_sched.sv
// rtl/mips_sort_sched.sv - round-robin scheduler sharing one mips_sort core among NREQ requesters
// Optional WAIT-state watchdog is enabled by defining SORT_SCHED_TIMEOUT_EN.
module mips_sort_sched #(
  parameter int NREQ           = 4,
  parameter int IDW            = $clog2(NREQ),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*256-1:0]   req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [255:0]          core_a,
  output logic                  core_start,
  input  logic [255:0]          core_out,
  input  logic [31:0]           core_ninst,
  input  logic                  core_done,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [255:0]          resp_data,
  output logic [31:0]           resp_ninst,
  output logic                  resp_err,
  output logic                  busy,
  output logic [15:0]           jobs_done,
  output logic [31:0]           total_inst
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mips_sort_sched: illegal parameter combination");
  end

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] cur_id;
  logic           done_q;
  logic           done_edge;
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [255:0]   grant_data;
  logic [32:0]    inst_sum;
  int             cand;
  logic [IDW-1:0] cand_idx;

  // Search last+1, last+2, ... so the most recently served requester goes last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (!grant_any && req[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) grant_data = req_data[i*256 +: 256];
    end
  end

  always_comb begin
    gnt = '0;
    if (state == S_IDLE && grant_any) gnt[grant_idx] = 1'b1;
  end

  assign done_edge = core_done && !done_q;
  assign busy      = (state != S_IDLE);
  assign inst_sum  = {1'b0, total_inst} + {1'b0, resp_ninst};

`ifdef SORT_SCHED_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wait_cnt;
  logic        err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      last       <= IDW'(NREQ - 1);
      cur_id     <= '0;
      core_a     <= '0;
      core_start <= 1'b0;
      done_q     <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_ninst <= '0;
      jobs_done  <= '0;
      total_inst <= '0;
`ifdef SORT_SCHED_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_q     <= core_done;
      core_start <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            core_a     <= grant_data;
            cur_id     <= grant_idx;
            last       <= grant_idx;
            core_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
`ifdef SORT_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Only a rising done counts; a level left high by the previous job is ignored.
          if (done_edge) begin
            resp_data  <= core_out;
            resp_ninst <= core_ninst;
            resp_id    <= cur_id;
            resp_valid <= 1'b1;
`ifdef SORT_SCHED_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            state      <= S_RESP;
          end
`ifdef SORT_SCHED_TIMEOUT_EN
          else if (wait_cnt == TMO_LAST) begin
            resp_data  <= '0;
            resp_ninst <= '0;
            resp_id    <= cur_id;
            resp_valid <= 1'b1;
            err_q      <= 1'b1;
            state      <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        S_RESP: begin
          if (!resp_err) begin
            jobs_done  <= jobs_done + 16'd1;
            total_inst <= inst_sum[32] ? 32'hFFFF_FFFF : inst_sum[31:0];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_sort_sched.sv
// tb/tb_mips_sort_sched.sv - scoreboard bench for mips_sort_sched with a behavioural sort core
module tb_mips_sort_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef SORT_SCHED_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic                clk;
  logic                rstn;
  logic [NREQ-1:0]     req;
  logic [NREQ*256-1:0] req_data;
  logic [NREQ-1:0]     gnt;
  logic [255:0]        core_a;
  logic                core_start;
  logic [255:0]        core_out;
  logic [31:0]         core_ninst;
  logic                core_done;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [255:0]        resp_data;
  logic [31:0]         resp_ninst;
  logic                resp_err;
  logic                busy;
  logic [15:0]         jobs_done;
  logic [31:0]         total_inst;

  mips_sort_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .gnt(gnt),
    .core_a(core_a), .core_start(core_start), .core_out(core_out),
    .core_ninst(core_ninst), .core_done(core_done), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_data(resp_data), .resp_ninst(resp_ninst),
    .resp_err(resp_err), .busy(busy), .jobs_done(jobs_done), .total_inst(total_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [IDW-1:0] id;
    logic [255:0]   data;
    logic [31:0]    ninst;
    logic           err;
  } exp_t;

  exp_t           exp_q[$];
  logic [IDW-1:0] gq[$];
  logic [255:0]   dq[NREQ][$];
  logic [31:0]    ninst_base;
  logic           core_hang;
  logic [15:0]    exp_jobs;
  logic [31:0]    exp_total;

  function automatic logic [255:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [255:0] sort8(input logic [255:0] d);
    int a[8];
    int t;
    logic [255:0] r;
    for (int k = 0; k < 8; k++) a[k] = $signed(d[k*32 +: 32]);
    for (int p = 0; p < 7; p++)
      for (int k = 0; k < 7 - p; k++)
        if (a[k] > a[k+1]) begin t = a[k]; a[k] = a[k+1]; a[k+1] = t; end
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(a[k]);
    return r;
  endfunction

  function automatic logic [31:0] ninst_of(input logic [31:0] base, input logic [255:0] d);
    return base + {24'b0, d[7:0]};
  endfunction

  task automatic expect_job(input int id, input logic [255:0] d, input logic err);
    exp_t e;
    e.id    = IDW'(id);
    e.err   = err;
    e.data  = err ? '0 : sort8(d);
    e.ninst = err ? '0 : ninst_of(ninst_base, d);
    exp_q.push_back(e);
    gq.push_back(IDW'(id));
  endtask

  function automatic bit all_idle();
    bit e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (dq[i].size() != 0) e = 1'b0;
    return e && exp_q.size() == 0 && gq.size() == 0 && !busy;
  endfunction

  task automatic wait_idle(input string tag, input int max);
    int c = 0;
    while (c < max && !all_idle()) begin @(negedge clk); c++; end
    chk(tag, all_idle(), 1);
  endtask

  task automatic wait_start(input string tag, input int max);
    int c = 0;
    while (c < max && !core_start) begin @(negedge clk); c++; end
    chk(tag, core_start, 1);
  endtask

  // Requesters: hold req while their queue is non-empty, drop the head once granted.
  initial begin : drv
    logic [NREQ-1:0] g;
    req = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      g = rstn ? gnt : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        req[i] = (dq[i].size() > 0);
        req_data[i*256 +: 256] = req[i] ? dq[i][0] : '0;
      end
    end
  end

  // Core model: done stays high from the previous job until 3 cycles after start, rises after 6.
  logic [255:0] m_in;
  logic [31:0]  m_base;
  logic         m_hang;
  logic         m_active;
  int           m_cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_done <= 1'b0; core_out <= '0; core_ninst <= '0;
      m_in <= '0; m_base <= '0; m_hang <= 1'b0; m_active <= 1'b0; m_cnt <= 0;
    end else if (core_start) begin
      m_active <= 1'b1; m_cnt <= 0; m_in <= core_a; m_base <= ninst_base; m_hang <= core_hang;
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 2) core_done <= 1'b0;
      if (m_cnt == 5 && !m_hang) begin
        core_out   <= sort8(m_in);
        core_ninst <= ninst_of(m_base, m_in);
        core_done  <= 1'b1;
        m_active   <= 1'b0;
      end
    end
  end

  // Monitor: grant order, latencies, responses and statistics.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [NREQ-1:0] oh;
    logic [32:0] s;
    static logic prev_gnt_any = 1'b0;
    static logic prev_resp    = 1'b0;
    static logic done_prev    = 1'b0;
    static logic resp_due     = 1'b0;
    static logic stats_due    = 1'b0;
    if (!rstn) begin
      prev_gnt_any = 1'b0; prev_resp = 1'b0; done_prev = 1'b0;
      resp_due = 1'b0; stats_due = 1'b0;
    end else begin
      chk("gnt_onehot0", $onehot0(gnt), 1);
      chk("start_latency", core_start, prev_gnt_any);
      if (!(resp_valid && resp_err)) chk("resp_latency", resp_valid, resp_due);
      if (prev_resp) chk("gnt_after_resp", gnt != '0, req != '0);
      if (gnt != '0) begin
        if (gq.size() == 0) chk("gnt_unexpected", gnt, '0);
        else begin
          oh = '0;
          oh[gq.pop_front()] = 1'b1;
          chk("gnt_order", gnt, oh);
        end
      end
      if (stats_due) begin
        chk("jobs_done", jobs_done, exp_jobs);
        chk("total_inst", total_inst, exp_total);
        stats_due = 1'b0;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("resp_unexpected", resp_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("resp_id", resp_id, e.id);
          chk("resp_data", resp_data, e.data);
          chk("resp_ninst", resp_ninst, e.ninst);
          chk("resp_err", resp_err, e.err);
          if (!e.err) begin
            exp_jobs = exp_jobs + 16'd1;
            s = {1'b0, exp_total} + {1'b0, e.ninst};
            exp_total = s[32] ? 32'hFFFF_FFFF : s[31:0];
          end
          stats_due = 1'b1;
        end
      end
      resp_due     = core_done && !done_prev && busy;
      done_prev    = core_done;
      prev_gnt_any = (gnt != '0);
      prev_resp    = resp_valid;
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gnt"}, gnt, '0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_a"}, core_a, '0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_id"}, resp_id, '0);
    chk({tag, "_resp_data"}, resp_data, '0);
    chk({tag, "_resp_ninst"}, resp_ninst, '0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_jobs_done"}, jobs_done, '0);
    chk({tag, "_total_inst"}, total_inst, '0);
  endtask

  initial begin : stim
    logic [255:0] d0, d1, d2, d3, da, db, dc, dd;
    int c;
    rstn = 1'b0; core_hang = 1'b0; ninst_base = 32'd1000;
    exp_jobs = '0; exp_total = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("in_reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_state("after_reset");

    // Contention: all four raised together, served 0,1,2,3.
    d0 = pack8(7, 6, 5, 4, 3, 2, 1, 0);
    d1 = pack8(100, -100, 50, -50, 25, -25, 0, 1);
    d2 = pack8(-1, -2, -3, -4, -5, -6, -7, -8);
    d3 = pack8(3, 3, 1, 1, 2, 2, 0, 0);
    dq[0].push_back(d0); dq[1].push_back(d1); dq[2].push_back(d2); dq[3].push_back(d3);
    expect_job(0, d0, 0); expect_job(1, d1, 0); expect_job(2, d2, 0); expect_job(3, d3, 0);
    wait_idle("contention_drain", 400);
    chk("contention_jobs", jobs_done, 16'd4);

    // Single job with the reference array.
    ninst_base = 32'd2000;
    d0 = pack8(22, 5, -9, 3, -17, 38, 0, 11);
    dq[0].push_back(d0);
    expect_job(0, d0, 0);
    wait_idle("single_drain", 100);
    chk("single_sorted", resp_data, pack8(-17, -9, 0, 3, 5, 11, 22, 38));
    chk("single_ninst", resp_ninst, 32'd2022);
    chk("single_jobs", jobs_done, 16'd5);

    // Fairness: req[1] continuous, req[2] joins after the first grant.
    ninst_base = 32'd300;
    da = pack8(9, 8, 7, 6, 5, 4, 3, 2);
    db = pack8(-5, 5, -4, 4, -3, 3, -2, 2);
    dc = pack8(1, 0, 1, 0, 1, 0, 1, 0);
    dd = pack8(64, -64, 32, -32, 16, -16, 8, -8);
    expect_job(1, da, 0); expect_job(2, dc, 0); expect_job(1, db, 0); expect_job(2, dd, 0);
    dq[1].push_back(da); dq[1].push_back(db);
    c = 0;
    while (c < 50 && dq[1].size() != 1) begin @(negedge clk); c++; end
    chk("fair_first_grant", dq[1].size(), 1);
    dq[2].push_back(dc); dq[2].push_back(dd);
    wait_idle("fair_drain", 300);

    // Saturation: bring total to FFFF_FFF0, then add 100.
    ninst_base = 32'hFFFF_FFF0 - exp_total;
    d3 = pack8(0, 9, 8, 7, 6, 5, 4, 3);
    dq[3].push_back(d3);
    expect_job(3, d3, 0);
    wait_idle("sat_pre_drain", 100);
    chk("sat_preload", total_inst, 32'hFFFF_FFF0);
    ninst_base = 32'd100;
    d3 = pack8(0, -1, 2, -3, 4, -5, 6, -7);
    dq[3].push_back(d3);
    expect_job(3, d3, 0);
    wait_idle("sat_drain", 100);
    chk("sat_total", total_inst, 32'hFFFF_FFFF);

`ifdef SORT_SCHED_TIMEOUT_EN
    // Watchdog: first job never completes, the queued second job is granted right after RESP.
    ninst_base = 32'd5;
    core_hang = 1'b1;
    d0 = pack8(4, 3, 2, 1, -1, -2, -3, -4);
    d1 = pack8(10, 20, 30, 40, 50, 60, 70, 80);
    expect_job(2, d0, 1); expect_job(2, d1, 0);
    dq[2].push_back(d0); dq[2].push_back(d1);
    wait_start("tmo_start", 50);
    @(negedge clk);
    core_hang = 1'b0;
    wait_idle("tmo_drain", 200);
`endif

    // Reset during WAIT aborts the job and restores the round-robin pointer.
    d0 = pack8(1, 2, 3, 4, 5, 6, 7, 8);
    dq[0].push_back(d0);
    gq.push_back(IDW'(0));
    wait_start("abort_start", 50);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    exp_jobs = '0;
    exp_total = '0;
    @(negedge clk);
    chk_reset_state("abort_in_reset");
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_start", core_start, 0);
    chk("abort_idle", busy, 0);
    ninst_base = 32'd7;
    d0 = pack8(-8, 7, -6, 5, -4, 3, -2, 1);
    d1 = pack8(11, 13, 12, 15, 14, 17, 16, 10);
    dq[1].push_back(d1); dq[0].push_back(d0);
    expect_job(0, d0, 0); expect_job(1, d1, 0);
    wait_idle("post_abort_drain", 200);
    chk("post_abort_jobs", jobs_done, 16'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

endmodule
